// File: rtl/compass_pkg.sv
// compass_pkg: shared constants, state encoding and arctangent table for
// the heading_cordic block.
//   WORK_W      : signed working width of the CORDIC x/y datapath
//   MAX_ITERS   : number of entries in the arctangent table
//   FULL_CIRCLE : 360 degrees in 1/64-degree units
//   HALF_CIRCLE : 180 degrees in 1/64-degree units
//   state_t     : controller states
//   atan_lut()  : atan(2^-i) in 1/64-degree units
package compass_pkg;

    localparam int WORK_W    = 20;
    localparam int MAX_ITERS = 12;

    localparam logic [15:0] FULL_CIRCLE = 16'd23040;
    localparam logic [15:0] HALF_CIRCLE = 16'd11520;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREROT = 2'd1,
        ST_ITER   = 2'd2,
        ST_ROUND  = 2'd3
    } state_t;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'd2880;
            4'd1:    val = 16'd1700;
            4'd2:    val = 16'd898;
            4'd3:    val = 16'd456;
            4'd4:    val = 16'd229;
            4'd5:    val = 16'd115;
            4'd6:    val = 16'd57;
            4'd7:    val = 16'd29;
            4'd8:    val = 16'd14;
            4'd9:    val = 16'd7;
            4'd10:   val = 16'd4;
            4'd11:   val = 16'd2;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_vector_step.sv
// cordic_vector_step: one combinational CORDIC micro-rotation in vectoring
// mode. Rotates (x, y) towards the +X axis and accumulates the rotated
// angle into z.
//   x_in, y_in : signed working-width vector
//   z_in       : angle accumulator, 1/64 degree, modulo 2^16
//   shift      : iteration index i (shift amount)
//   atan       : atan(2^-i) in 1/64 degree
//   x_out, y_out, z_out : rotated vector and updated angle
module cordic_vector_step
    import compass_pkg::*;
(
    input  logic signed [WORK_W-1:0] x_in,
    input  logic signed [WORK_W-1:0] y_in,
    input  logic        [15:0]       z_in,
    input  logic        [3:0]        shift,
    input  logic        [15:0]       atan,
    output logic signed [WORK_W-1:0] x_out,
    output logic signed [WORK_W-1:0] y_out,
    output logic        [15:0]       z_out
);

    logic signed [WORK_W-1:0] x_sh;
    logic signed [WORK_W-1:0] y_sh;

    assign x_sh = x_in >>> shift;
    assign y_sh = y_in >>> shift;

    // Both updates use the pre-rotation x and y.
    always_comb begin
        x_out = x_in;
        y_out = y_in;
        z_out = z_in;
        if (!y_in[WORK_W-1]) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan;
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan;
        end
    end

endmodule

// File: rtl/heading_cordic.sv
// heading_cordic: converts raw magnetometer X/Y codes into a compass heading
// in whole degrees (0..359, counter-clockwise from +X) using an iterative
// vectoring CORDIC, one micro-rotation per clock.
//   iclk, rst       : clock; synchronous active-high reset
//   sample_valid    : one-cycle pulse, mag_x/mag_y valid
//   mag_x, mag_y    : raw offset-binary sensor codes
//   x_off, y_off    : signed hard-iron offsets (sensor counts)
//   heading         : last computed heading, held between updates
//   heading_valid   : one-cycle pulse when heading updates
//   busy            : computation in flight
//   overrun         : sticky, a pending sample was overwritten
module heading_cordic
    import compass_pkg::*;
#(
    parameter int          ITERS      = 12,
    parameter logic [15:0] ZERO_FIELD = 16'h8000
) (
    input  logic        iclk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] mag_x,
    input  logic [15:0] mag_y,
    input  logic [15:0] x_off,
    input  logic [15:0] y_off,
    output logic [8:0]  heading,
    output logic        heading_valid,
    output logic        busy,
    output logic        overrun
);

    state_t                   state_reg;
    logic [3:0]               iter_reg;
    logic signed [WORK_W-1:0] x_reg;
    logic signed [WORK_W-1:0] y_reg;
    logic [15:0]              z_reg;
    logic [15:0]              raw_x_reg;
    logic [15:0]              raw_y_reg;
    logic                     pend_full_reg;
    logic [15:0]              pend_x_reg;
    logic [15:0]              pend_y_reg;
    logic [8:0]               heading_reg;
    logic                     heading_valid_reg;
    logic                     overrun_reg;

    // Offset correction; all terms widened to the working width so the
    // result cannot overflow.
    logic signed [WORK_W-1:0] x_corr;
    logic signed [WORK_W-1:0] y_corr;

    assign x_corr = $signed({4'b0000, raw_x_reg}) - $signed({4'b0000, ZERO_FIELD})
                  - $signed({{4{x_off[15]}}, x_off});
    assign y_corr = $signed({4'b0000, raw_y_reg}) - $signed({4'b0000, ZERO_FIELD})
                  - $signed({{4{y_off[15]}}, y_off});

    // Single shared micro-rotation stage.
    logic signed [WORK_W-1:0] x_step;
    logic signed [WORK_W-1:0] y_step;
    logic [15:0]              z_step;

    cordic_vector_step u_step (
        .x_in  (x_reg),
        .y_in  (y_reg),
        .z_in  (z_reg),
        .shift (iter_reg),
        .atan  (atan_lut(iter_reg)),
        .x_out (x_step),
        .y_out (y_step),
        .z_out (z_step)
    );

    // z never exceeds ~18000 or drops below ~-6400, so bit 15 set means a
    // negative angle; adding a full circle in 16-bit arithmetic wraps it
    // back into 0..23039.
    logic [15:0] z_mod;
    logic [8:0]  deg_round;
    logic [8:0]  heading_calc;

    assign z_mod        = z_reg[15] ? (z_reg + FULL_CIRCLE) : z_reg;
    assign deg_round    = 9'((z_mod + 16'd32) >> 6);
    assign heading_calc = (deg_round == 9'd360) ? 9'd0 : deg_round;

    always_ff @(posedge iclk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            iter_reg          <= 4'd0;
            x_reg             <= '0;
            y_reg             <= '0;
            z_reg             <= 16'd0;
            raw_x_reg         <= 16'd0;
            raw_y_reg         <= 16'd0;
            pend_full_reg     <= 1'b0;
            pend_x_reg        <= 16'd0;
            pend_y_reg        <= 16'd0;
            heading_reg       <= 9'd0;
            heading_valid_reg <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            heading_valid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (sample_valid) begin
                        // A fresh sample supersedes a waiting one.
                        raw_x_reg     <= mag_x;
                        raw_y_reg     <= mag_y;
                        pend_full_reg <= 1'b0;
                        if (pend_full_reg) begin
                            overrun_reg <= 1'b1;
                        end
                        state_reg     <= ST_PREROT;
                    end else if (pend_full_reg) begin
                        raw_x_reg     <= pend_x_reg;
                        raw_y_reg     <= pend_y_reg;
                        pend_full_reg <= 1'b0;
                        state_reg     <= ST_PREROT;
                    end
                end

                ST_PREROT: begin
                    iter_reg <= 4'd0;
                    if (x_corr == '0 && y_corr == '0) begin
                        x_reg     <= '0;
                        y_reg     <= '0;
                        z_reg     <= 16'd0;
                        state_reg <= ST_ROUND;
                    end else if (x_corr[WORK_W-1]) begin
                        // Fold the left half-plane onto the right one.
                        x_reg     <= -x_corr;
                        y_reg     <= -y_corr;
                        z_reg     <= HALF_CIRCLE;
                        state_reg <= ST_ITER;
                    end else begin
                        x_reg     <= x_corr;
                        y_reg     <= y_corr;
                        z_reg     <= 16'd0;
                        state_reg <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    x_reg    <= x_step;
                    y_reg    <= y_step;
                    z_reg    <= z_step;
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'(ITERS - 1)) begin
                        state_reg <= ST_ROUND;
                    end
                end

                ST_ROUND: begin
                    heading_reg       <= heading_calc;
                    heading_valid_reg <= 1'b1;
                    state_reg         <= ST_IDLE;
                end

                default: state_reg <= ST_IDLE;
            endcase

            // Samples arriving mid-computation (including the ROUND edge)
            // park in the one-entry slot; latest wins.
            if (sample_valid && state_reg != ST_IDLE) begin
                pend_x_reg    <= mag_x;
                pend_y_reg    <= mag_y;
                pend_full_reg <= 1'b1;
                if (pend_full_reg) begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign heading       = heading_reg;
    assign heading_valid = heading_valid_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_heading_cordic.sv
// tb_heading_cordic: self-checking bench for heading_cordic. Directed table
// vectors, a full-circle sweep and random vectors are compared against an
// exact atan2 reference; hand-written sequences cover pending/overrun and
// reset during a computation.
module tb_heading_cordic;

    logic        iclk;
    logic        rst;
    logic        sample_valid;
    logic [15:0] mag_x;
    logic [15:0] mag_y;
    logic [15:0] x_off;
    logic [15:0] y_off;
    logic [8:0]  heading;
    logic        heading_valid;
    logic        busy;
    logic        overrun;

    int vectors;
    int miscompares;

    heading_cordic dut (
        .iclk          (iclk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .mag_x         (mag_x),
        .mag_y         (mag_y),
        .x_off         (x_off),
        .y_off         (y_off),
        .heading       (heading),
        .heading_valid (heading_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic [15:0] mx;
        logic [15:0] my;
        logic [15:0] xo;
        logic [15:0] yo;
        int          exp_hd;
        int          tol;
        int          exp_lat;
    } vec_t;

    // Exact heading in degrees, 0 <= h < 360.
    function automatic real exact_deg(input int x, input int y);
        real r;
        r = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
        if (r < 0.0) r = r + 360.0;
        return r;
    endfunction

    function automatic real circ_diff(input int hd, input real e);
        real d;
        d = real'(hd) - e;
        if (d < 0.0) d = -d;
        if (d > 180.0) d = 360.0 - d;
        return d;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_angle(input string name, input int hd, input real exp, input real tol);
        vectors++;
        if (hd < 0 || hd > 359 || circ_diff(hd, exp) > tol) begin
            miscompares++;
            $display("FAIL %s: got heading %0d, expected %0.2f +/- %0.1f", name, hd, exp, tol);
        end
    endtask

    // Pulse one sample in IDLE and wait for its result. lat counts edges
    // after the sampling edge; -1 when no result arrives in time.
    task automatic apply(input logic [15:0] mx, input logic [15:0] my,
                         input logic [15:0] xo, input logic [15:0] yo,
                         output int lat, output int hd, output int busy_mid);
        lat      = -1;
        hd       = 511;
        busy_mid = -1;
        @(negedge iclk);
        mag_x        = mx;
        mag_y        = my;
        x_off        = xo;
        y_off        = yo;
        sample_valid = 1'b1;
        @(posedge iclk);
        for (int k = 0; k < 40; k++) begin
            @(negedge iclk);
            sample_valid = 1'b0;
            if (k == 0) busy_mid = int'(busy);
            if (heading_valid) begin
                lat = k;
                hd  = int'(heading);
                break;
            end
        end
    endtask

    vec_t tbl[11];

    initial begin
        int lat;
        int hd;
        int bm;
        int nvalid;
        int vk[2];
        int vh[2];

        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        mag_x        = 16'h0000;
        mag_y        = 16'h0000;
        x_off        = 16'h0000;
        y_off        = 16'h0000;

        tbl[0]  = '{16'h8000 + 16'd1000, 16'h8000,             16'h0000, 16'h0000, 0,   0, 14};
        tbl[1]  = '{16'h8000,             16'h8000 + 16'd1000, 16'h0000, 16'h0000, 90,  0, 14};
        tbl[2]  = '{16'h8000 - 16'd1000, 16'h8000,             16'h0000, 16'h0000, 180, 0, 14};
        tbl[3]  = '{16'h8000,             16'h8000 - 16'd1000, 16'h0000, 16'h0000, 270, 0, 14};
        tbl[4]  = '{16'h8000 + 16'd1000, 16'h8000 + 16'd1000, 16'h0000, 16'h0000, 45,  0, 14};
        tbl[5]  = '{16'h8000 + 16'd1000, 16'h8000 - 16'd577,  16'h0000, 16'h0000, 330, 1, 14};
        tbl[6]  = '{16'h8000 + 16'd1200, 16'h8000 - 16'd300,  16'd200,  16'hFED4, 0,   0, 14};
        tbl[7]  = '{16'h8000 + 16'd200,  16'h8000 - 16'd300,  16'd200,  16'hFED4, 0,   0, 2};
        tbl[8]  = '{16'h8000,             16'h8000,             16'h0000, 16'h0000, 0,   0, 2};
        tbl[9]  = '{16'hFFFF,             16'h0000,             16'h8000, 16'h8000, 0,   1, 14};
        tbl[10] = '{16'h0000,             16'hFFFF,             16'h7FFF, 16'h8000, 135, 1, 14};

        repeat (3) @(negedge iclk);
        check_int("rst_heading", int'(heading), 0);
        check_int("rst_valid", int'(heading_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        @(negedge iclk);
        check_int("idle_busy", int'(busy), 0);

        // Directed table.
        for (int t = 0; t < 11; t++) begin
            apply(tbl[t].mx, tbl[t].my, tbl[t].xo, tbl[t].yo, lat, hd, bm);
            $display("table %0d: mag_x=%h mag_y=%h x_off=%h y_off=%h -> heading %0d latency %0d",
                     t, tbl[t].mx, tbl[t].my, tbl[t].xo, tbl[t].yo, hd, lat);
            check_int("table_latency", lat, tbl[t].exp_lat);
            check_int("table_busy_mid", bm, 1);
            check_angle("table_heading", hd, real'(tbl[t].exp_hd), real'(tbl[t].tol));
            check_int("table_busy_done", int'(busy), 0);
        end

        // Full-circle sweep at radius 4000, plus points either side of 0/360.
        for (int d = 0; d <= 361; d++) begin
            real a;
            int  x;
            int  y;
            if (d == 360)      a = 359.6;
            else if (d == 361) a = 0.4;
            else               a = real'(d);
            x = int'(4000.0 * $cos(a * 3.14159265358979 / 180.0));
            y = int'(4000.0 * $sin(a * 3.14159265358979 / 180.0));
            apply(16'(32768 + x), 16'(32768 + y), 16'h0000, 16'h0000, lat, hd, bm);
            $display("sweep %0.1f deg: x=%0d y=%0d -> heading %0d latency %0d", a, x, y, hd, lat);
            check_int("sweep_latency", lat, 14);
            check_angle("sweep_heading", hd, exact_deg(x, y), 1.0);
        end

        // Random vectors with random hard-iron offsets.
        for (int r = 0; r < 150; r++) begin
            int x;
            int y;
            int xo;
            int yo;
            x  = int'($urandom_range(256, 30000));
            y  = int'($urandom_range(256, 30000));
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 1) == 1) y = -y;
            xo = int'($urandom_range(0, 4000)) - 2000;
            yo = int'($urandom_range(0, 4000)) - 2000;
            apply(16'(32768 + x + xo), 16'(32768 + y + yo), 16'(xo), 16'(yo), lat, hd, bm);
            $display("random %0d: x=%0d y=%0d xo=%0d yo=%0d -> heading %0d latency %0d",
                     r, x, y, xo, yo, hd, lat);
            check_int("random_latency", lat, 14);
            check_angle("random_heading", hd, exact_deg(x, y), 1.0);
        end

        // Three samples 3 cycles apart: second is overwritten by the third.
        nvalid = 0;
        vk[0] = -1; vk[1] = -1; vh[0] = -1; vh[1] = -1;
        x_off = 16'h0000;
        y_off = 16'h0000;
        @(negedge iclk);
        mag_x        = 16'h8000 + 16'd1000;
        mag_y        = 16'h8000;
        sample_valid = 1'b1;
        @(posedge iclk);
        for (int k = 0; k < 45; k++) begin
            @(negedge iclk);
            sample_valid = 1'b0;
            if (heading_valid) begin
                if (nvalid < 2) begin
                    vk[nvalid] = k;
                    vh[nvalid] = int'(heading);
                end
                nvalid++;
            end
            if (k == 2) begin
                mag_x        = 16'h8000;
                mag_y        = 16'h8000 + 16'd1000;
                sample_valid = 1'b1;
            end
            if (k == 5) begin
                mag_x        = 16'h8000 - 16'd1000;
                mag_y        = 16'h8000;
                sample_valid = 1'b1;
            end
        end
        $display("overrun seq: %0d results at edges %0d,%0d headings %0d,%0d overrun %0d",
                 nvalid, vk[0], vk[1], vh[0], vh[1], overrun);
        check_int("ovr_count", nvalid, 2);
        check_int("ovr_first_edge", vk[0], 14);
        check_int("ovr_second_edge", vk[1], 29);
        check_int("ovr_first_heading", vh[0], 0);
        check_int("ovr_second_heading", vh[1], 180);
        check_int("ovr_flag", int'(overrun), 1);
        check_int("ovr_heading_hold", int'(heading), 180);

        // Reset at edge N+7 of a computation.
        nvalid = 0;
        @(negedge iclk);
        mag_x        = 16'h8000;
        mag_y        = 16'h8000 + 16'd1000;
        sample_valid = 1'b1;
        @(posedge iclk);
        for (int k = 0; k < 28; k++) begin
            @(negedge iclk);
            sample_valid = 1'b0;
            if (k == 0) check_int("rstmid_busy_before", int'(busy), 1);
            if (k == 6) rst = 1'b1;
            if (k == 7) begin
                rst = 1'b0;
                check_int("rstmid_heading", int'(heading), 0);
                check_int("rstmid_valid", int'(heading_valid), 0);
                check_int("rstmid_busy", int'(busy), 0);
                check_int("rstmid_overrun", int'(overrun), 0);
            end
            if (k >= 7 && heading_valid) nvalid++;
        end
        $display("reset seq: %0d results after abort", nvalid);
        check_int("rstmid_no_valid", nvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
